// File: rtl/vdp_timing_pkg.sv
// vdp_timing_pkg: DOTSTATE phase codes and dot/line counter limits
// shared by the VDP timing and render stages.
package vdp_timing_pkg;

    typedef enum logic [1:0] {
        DS_P0 = 2'b00,
        DS_P1 = 2'b01,
        DS_P2 = 2'b11,
        DS_P3 = 2'b10
    } dotstate_t;

    localparam logic [8:0] COUNT_FIRST     = 9'h1F8;
    localparam logic [8:0] ACTIVE_LAST_192 = 9'd191;
    localparam logic [8:0] ACTIVE_LAST_212 = 9'd211;

    // Negative line numbers are blanking; the window starts at line 0.
    function automatic logic in_window(
        input logic [8:0] yp,
        input logic       ln
    );
        logic [8:0] last;
        last = ln ? ACTIVE_LAST_212 : ACTIVE_LAST_192;
        return !yp[8] && (yp <= last);
    endfunction

endpackage

// File: rtl/vdp_wrap_counter.sv
// vdp_wrap_counter: 9-bit two's complement counter that runs from
// COUNT_FIRST up to LAST and reloads COUNT_FIRST when enabled at LAST.
module vdp_wrap_counter
    import vdp_timing_pkg::*;
#(
    parameter int LAST = 341
) (
    input  logic       CLK21M,
    input  logic       RESET_N,
    input  logic       en,
    output logic [8:0] count,
    output logic       wrap
);

    localparam logic [8:0] LAST_V = 9'(LAST);

    assign wrap = (count == LAST_V);

    always_ff @(posedge CLK21M or negedge RESET_N) begin
        if (!RESET_N) begin
            count <= COUNT_FIRST;
        end else if (en) begin
            count <= wrap ? COUNT_FIRST : count + 9'd1;
        end
    end

endmodule

// File: rtl/vdp_dot_timing.sv
// vdp_dot_timing: dot phase, dot/line counters and vertical window.
// Define VDP_DOT_TIMING_FIELD_EN to get a toggling FIELD output.
module vdp_dot_timing
    import vdp_timing_pkg::*;
#(
    parameter int H_LAST = 341,
    parameter int V_LAST = 264
) (
    input  logic       CLK21M,
    input  logic       RESET_N,
    input  logic       REG_R9_LN,
    output logic [1:0] DOTSTATE,
    output logic [2:0] EIGHTDOTSTATE,
    output logic [8:0] DOTCOUNTERX,
    output logic [8:0] DOTCOUNTERYP,
    output logic       BWINDOW_Y,
    output logic       LINE_START,
    output logic       FRAME_START,
    output logic       FIELD
);

    dotstate_t  state_q;
    dotstate_t  state_d;
    logic       x_en;
    logic       x_wrap;
    logic       y_en;
    logic       y_wrap;
    logic [8:0] yp_next;

    always_ff @(posedge CLK21M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= DS_P3;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DS_P0: state_d = DS_P1;
            DS_P1: state_d = DS_P2;
            DS_P2: state_d = DS_P3;
            DS_P3: state_d = DS_P0;
        endcase
    end

    always_comb begin
        DOTSTATE = state_q;
    end

    assign x_en = (state_q == DS_P2);
    assign y_en = x_en && x_wrap;

    vdp_wrap_counter #(
        .LAST    (H_LAST)
    ) u_cnt_x (
        .CLK21M  (CLK21M),
        .RESET_N (RESET_N),
        .en      (x_en),
        .count   (DOTCOUNTERX),
        .wrap    (x_wrap)
    );

    vdp_wrap_counter #(
        .LAST    (V_LAST)
    ) u_cnt_yp (
        .CLK21M  (CLK21M),
        .RESET_N (RESET_N),
        .en      (y_en),
        .count   (DOTCOUNTERYP),
        .wrap    (y_wrap)
    );

    assign yp_next = y_wrap ? COUNT_FIRST : DOTCOUNTERYP + 9'd1;

    // EIGHTDOTSTATE trails DOTCOUNTERX[2:0] by one clock on purpose.
    always_ff @(posedge CLK21M or negedge RESET_N) begin
        if (!RESET_N) begin
            EIGHTDOTSTATE <= 3'd0;
        end else if (state_q == DS_P3) begin
            EIGHTDOTSTATE <= DOTCOUNTERX[2:0];
        end
    end

    always_ff @(posedge CLK21M or negedge RESET_N) begin
        if (!RESET_N) begin
            BWINDOW_Y   <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            LINE_START  <= y_en;
            FRAME_START <= y_en && y_wrap;
            if (y_en) begin
                BWINDOW_Y <= in_window(yp_next, REG_R9_LN);
            end
        end
    end

`ifdef VDP_DOT_TIMING_FIELD_EN
    always_ff @(posedge CLK21M or negedge RESET_N) begin
        if (!RESET_N) begin
            FIELD <= 1'b0;
        end else if (y_en && y_wrap) begin
            FIELD <= ~FIELD;
        end
    end
`else
    assign FIELD = 1'b0;
`endif

endmodule

// File: tb/tb_vdp_dot_timing.sv
// tb_vdp_dot_timing: directed run of vdp_dot_timing with a queued
// reference model; uses short lines so several frames fit the budget.
module tb_vdp_dot_timing;

    localparam int HL        = 11;
    localparam int VL        = 215;
    localparam int L         = HL + 9;
    localparam int F         = VL + 9;
    localparam int LINE_CLK  = 4 * L;
    localparam int FRAME_CLK = 4 * L * F;

    typedef struct packed {
        logic [1:0] ds;
        logic [2:0] eds;
        logic [8:0] x;
        logic [8:0] yp;
        logic       bw;
        logic       ls;
        logic       fs;
        logic       fld;
    } obs_t;

    localparam obs_t RST = '{ds: 2'b10, eds: 3'd0, x: 9'h1F8,
                             yp: 9'h1F8, bw: 1'b0, ls: 1'b0,
                             fs: 1'b0, fld: 1'b0};

    logic       CLK21M    = 1'b0;
    logic       RESET_N   = 1'b0;
    logic       REG_R9_LN = 1'b0;
    logic [1:0] DOTSTATE;
    logic [2:0] EIGHTDOTSTATE;
    logic [8:0] DOTCOUNTERX;
    logic [8:0] DOTCOUNTERYP;
    logic       BWINDOW_Y;
    logic       LINE_START;
    logic       FRAME_START;
    logic       FIELD;

    obs_t q[$];
    int   n;
    int   passes;
    int   total;
    int   last_ls;
    int   last_fs;
    int   win_cnt;
    logic r9_eff;

    always #5 CLK21M = ~CLK21M;

    vdp_dot_timing #(
        .H_LAST        (HL),
        .V_LAST        (VL)
    ) dut (
        .CLK21M        (CLK21M),
        .RESET_N       (RESET_N),
        .REG_R9_LN     (REG_R9_LN),
        .DOTSTATE      (DOTSTATE),
        .EIGHTDOTSTATE (EIGHTDOTSTATE),
        .DOTCOUNTERX   (DOTCOUNTERX),
        .DOTCOUNTERYP  (DOTCOUNTERYP),
        .BWINDOW_Y     (BWINDOW_Y),
        .LINE_START    (LINE_START),
        .FRAME_START   (FRAME_START),
        .FIELD         (FIELD)
    );

    // Expected outputs after k edges since reset release.
    function automatic obs_t model(input int k, input logic r9);
        obs_t e;
        int   dots;
        int   lines;
        int   xi;
        int   yi;
        int   xe;
        e     = RST;
        dots  = k / 4;
        lines = dots / L;
        xi    = dots % L - 8;
        yi    = lines % F - 8;
        case (k % 4)
            0:       e.ds = 2'b10;
            1:       e.ds = 2'b00;
            2:       e.ds = 2'b01;
            default: e.ds = 2'b11;
        endcase
        e.x  = 9'(xi);
        e.yp = 9'(yi);
        if (k > 0) begin
            xe    = ((k - 1) / 4) % L - 8;
            e.eds = 3'(xe);
        end
        e.ls = (k > 0) && (k % 4 == 0) && (dots % L == 0);
        e.fs = e.ls && (lines % F == 0);
        e.bw = (yi >= 0) && (yi <= (r9 ? 211 : 191));
`ifdef VDP_DOT_TIMING_FIELD_EN
        e.fld = ((lines / F) % 2) == 1;
`else
        e.fld = 1'b0;
`endif
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.ds  = DOTSTATE;
        o.eds = EIGHTDOTSTATE;
        o.x   = DOTCOUNTERX;
        o.yp  = DOTCOUNTERYP;
        o.bw  = BWINDOW_Y;
        o.ls  = LINE_START;
        o.fs  = FRAME_START;
        o.fld = FIELD;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cmp_all(input obs_t o, input obs_t e);
        chk("dotstate", 32'(o.ds), 32'(e.ds));
        chk("eightdot", 32'(o.eds), 32'(e.eds));
        chk("counter_x", 32'(o.x), 32'(e.x));
        chk("counter_yp", 32'(o.yp), 32'(e.yp));
        chk("bwindow_y", 32'(o.bw), 32'(e.bw));
        chk("line_start", 32'(o.ls), 32'(e.ls));
        chk("frame_start", 32'(o.fs), 32'(e.fs));
        chk("field", 32'(o.fld), 32'(e.fld));
    endtask

    task automatic step(output obs_t o);
        obs_t e;
        if (((n + 1) % 4 == 0) && (((n + 1) / 4) % L == 0)) begin
            r9_eff = REG_R9_LN;
        end
        q.push_back(model(n + 1, r9_eff));
        @(posedge CLK21M);
        #1;
        n++;
        o = sample();
        e = q.pop_front();
        cmp_all(o, e);
        if (o.ls) begin
            if (last_ls >= 0) chk("line_period", n - last_ls, LINE_CLK);
            last_ls = n;
            if (o.bw) win_cnt++;
        end
        if (o.fs) begin
            chk("fs_with_ls", 32'(o.ls), 1);
            if (last_fs >= 0) chk("frame_period", n - last_fs, FRAME_CLK);
            last_fs = n;
        end
    endtask

    task automatic phase_run();
        obs_t o;
        logic [1:0] ph [5];
        ph = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        for (int i = 0; i < 5; i++) begin
            step(o);
            chk("phase_seq", 32'(o.ds), 32'(ph[i]));
            if (i == 3) chk("x_after_edge4", 32'(o.x), 32'h1F9);
            if (i == 4) chk("eds_after_edge5", 32'(o.eds), 1);
        end
    endtask

    task automatic run_frame(input int want_lines);
        obs_t o;
        bit   done;
        done = 0;
        for (int i = 0; i < FRAME_CLK + LINE_CLK && !done; i++) begin
            step(o);
            done = o.fs;
        end
        if (!done) chk("frame_timeout", 0, 1);
        chk("window_lines", win_cnt, want_lines);
        win_cnt = 0;
    endtask

    task automatic run_until(input int yp, input int x);
        obs_t o;
        bit   done;
        done = 0;
        for (int i = 0; i < FRAME_CLK + LINE_CLK && !done; i++) begin
            step(o);
            done = (o.yp == 9'(yp)) && (o.x == 9'(x));
        end
        if (!done) chk("seek_timeout", 0, 1);
    endtask

    initial begin
        obs_t o;
        bit   seen;
        n       = 0;
        passes  = 0;
        total   = 0;
        last_ls = -1;
        last_fs = -1;
        win_cnt = 0;
        r9_eff  = 1'b0;

        repeat (50) begin
            @(posedge CLK21M);
            #1;
            cmp_all(sample(), RST);
        end
        RESET_N = 1'b1;
        phase_run();

        run_frame(192);

        // Raise the 212-line select in the middle of a blank line.
        run_until(195, 5);
        REG_R9_LN = 1'b1;
        seen = 0;
        for (int i = 0; i < LINE_CLK + 4 && !seen; i++) begin
            step(o);
            if (!o.ls) chk("r9_mid_line_hold", 32'(o.bw), 0);
            seen = o.ls;
        end
        if (!seen) chk("line_timeout", 0, 1);
        chk("r9_at_line_edge_bw", 32'(o.bw), 1);
        chk("r9_at_line_edge_yp", 32'(o.yp), 196);

        run_frame(208);
        run_frame(212);

        run_until(50, 10);
        #3;
        RESET_N = 1'b0;
        #1;
        cmp_all(sample(), RST);
        repeat (10) begin
            @(posedge CLK21M);
            #1;
            cmp_all(sample(), RST);
        end
        RESET_N = 1'b1;
        n       = 0;
        last_ls = -1;
        last_fs = -1;
        win_cnt = 0;
        phase_run();
        for (int i = 0; i < 3 * LINE_CLK; i++) step(o);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/vdp_dot_timing.md
# vdp_dot_timing

Dot/line timing generator for the VDP: it produces the 4-phase DOTSTATE sequence, the 8-dot sub-phase, and the horizontal and vertical dot counters. It also produces the vertical display window flag and line/frame start strobes. It sits directly upstream of VDP_SPRITE and the other VDP render stages. Those stages consume DOTSTATE, EIGHTDOTSTATE, DOTCOUNTERX, DOTCOUNTERYP and BWINDOW_Y unchanged.

## Interface
Parameters:
- H_LAST, 341: last DOTCOUNTERX value before wrap. Line length is H_LAST+9 dots.
- V_LAST, 264: last DOTCOUNTERYP value before wrap. Frame length is V_LAST+9 lines.

Ports:
- CLK21M  in  1  21.48 MHz master clock.
- RESET_N  in  1  asynchronous, active-low reset.
- REG_R9_LN  in  1  0 selects a 192-line active window; 1 selects 212 lines.
- DOTSTATE  out  2  dot phase: 00→01→11→10→00.
- EIGHTDOTSTATE  out  3  8-dot sub-phase.
- DOTCOUNTERX  out  9  horizontal dot counter, two's complement, range −8..H_LAST.
- DOTCOUNTERYP  out  9  vertical line counter, two's complement, range −8..V_LAST.
- BWINDOW_Y  out  1  high while the current line is inside the active display window.
- LINE_START  out  1  one-clock strobe on DOTCOUNTERX wrap.
- FRAME_START  out  1  one-clock strobe on DOTCOUNTERYP wrap.
- FIELD  out  1  frame parity.

## Operation
- All outputs are registered. There are no combinational paths from input to output.
- Reset values while RESET_N=0:
  - DOTSTATE=2'b10, EIGHTDOTSTATE=0.
  - DOTCOUNTERX=9'h1F8 (−8), DOTCOUNTERYP=9'h1F8 (−8).
  - BWINDOW_Y=0, LINE_START=0, FRAME_START=0, FIELD=0.
- DOTSTATE is a 4-state machine that advances every clock: 00→01, 01→11, 11→10, 10→00. It has no stall input. The unreachable encoding does not exist because all four codes are legal.
- EIGHTDOTSTATE loads DOTCOUNTERX[2:0] on any edge where DOTSTATE==10. Otherwise it holds.
- DOTCOUNTERX advances on any edge where DOTSTATE==11:
  - If it equals H_LAST, it loads −8.
  - Otherwise it loads +1, using 9-bit modular arithmetic.
- DOTCOUNTERYP advances on the same edge where DOTCOUNTERX wraps (DOTSTATE==11 and DOTCOUNTERX==H_LAST):
  - If it equals V_LAST, it loads −8.
  - Otherwise it loads +1.
- BWINDOW_Y updates on the same edge as DOTCOUNTERYP, so the two are always coherent.
  - It is 1 iff the next DOTCOUNTERYP, read as signed, is in 0..191 (REG_R9_LN=0) or 0..211 (REG_R9_LN=1).
  - REG_R9_LN is sampled only at that edge. A mid-line change takes effect at the next line boundary.
- LINE_START is 1 for exactly the clock following a DOTCOUNTERX wrap edge.
- FRAME_START is 1 for exactly the clock following a DOTCOUNTERYP wrap edge. It always coincides with LINE_START.
- Asserting RESET_N mid-operation returns all outputs to their reset values immediately, without waiting for a clock edge.
- After reset is released, the sequence restarts deterministically from the reset values.

## Timing
- Counting edges from the first rising edge after RESET_N is released:
  - Edge 1: DOTSTATE becomes 00, EIGHTDOTSTATE loads 0.
  - Edge 2: DOTSTATE becomes 01.
  - Edge 3: DOTSTATE becomes 11.
  - Edge 4: DOTSTATE becomes 10 and DOTCOUNTERX becomes −7.
  - Edge 5: EIGHTDOTSTATE becomes 1.
- One dot is 4 clocks. One line is 4×(H_LAST+9) clocks, which is 1400 with the defaults.
- One frame is (V_LAST+9) lines, which is 273 with the defaults.
- EIGHTDOTSTATE lags DOTCOUNTERX[2:0] by 1 clock. This lag is intentional: downstream stages rely on it.

## Configuration
- The macro is VDP_DOT_TIMING_FIELD_EN.
- When it is defined:
  - FIELD toggles on every DOTCOUNTERYP wrap edge, so it is valid from the clock on which FRAME_START is high.
  - Reset value is 0.
- When it is undefined, FIELD is tied to 0 and no toggle flop is inferred.

## Structure
- Shared package vdp_timing_pkg holds:
  - The DOTSTATE phase constants (DS_P0=2'b00, DS_P1=2'b01, DS_P2=2'b11, DS_P3=2'b10).
  - The counter start value (COUNT_FIRST=9'h1F8).
  - The active line limits (ACTIVE_LAST_192=191, ACTIVE_LAST_212=211).
- One sub-module is natural: vdp_wrap_counter. It is a 9-bit counter with enable, a parameterised last value, and reload to COUNT_FIRST, and it exposes a wrap flag. It is instantiated twice, once for X and once for YP.

## Test plan
- Reset and phase: hold RESET_N=0 for 50 clocks, then release. Required: all reset values hold while asserted, then DOTSTATE follows 00,01,11,10 repeating, with X=−7 after edge 4 and EIGHTDOTSTATE=1 after edge 5.
- Line wrap: run to DOTCOUNTERX=341. Required: on the next DOTSTATE==11 edge, X becomes −8 and YP increments by 1; LINE_START is high for 1 clock; the period is 1400 clocks.
- Window, 192 lines: REG_R9_LN=0, run one frame. Required: BWINDOW_Y is high for exactly 192 lines, rising when YP becomes 0 and falling when YP becomes 192.
- Window, 212 lines: set REG_R9_LN=1 mid-line. Required: no change until the next line edge, then a window of 212 lines per frame.
- Frame wrap: run to YP=264 and X=341. Required: YP and X both become −8 on the same edge; FRAME_START and LINE_START are both high for 1 clock; frame length is 382200 clocks. FIELD toggles with VDP_DOT_TIMING_FIELD_EN and stays 0 without it.
- Reset mid-line: drive RESET_N low at X=100, YP=50, between clock edges. Required: outputs return to reset values immediately, and the post-release sequence is identical to the first scenario.
